num_ascii_formatter: RTL
========================

Name: num_ascii_formatter

Overview:
Reads signed integers back out of the number storage RAM and renders each one as decimal ASCII on a byte stream for the UART TX path. This is the reverse of the ASCII-to-number separator path. It drives the RAM read port with 1-cycle registered-read latency. Output format: numbers separated by SEP_CHAR, the list terminated by EOL_CHAR.

Parameters:
DATA_WIDTH, 32, stored integer width; only 32 supported (elaboration assertion).
ADDR_WIDTH, 11, RAM address width.
SEP_CHAR, 8'h20, byte emitted between numbers.
EOL_CHAR, 8'h0A, byte emitted after the last number.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a job when idle
base_addr  in  ADDR_WIDTH  first RAM address, sampled on accepted start
num_count  in  ADDR_WIDTH+1  number of integers to print (0..2^ADDR_WIDTH), sampled on start
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse after EOL byte transferred
rd_addr  out  ADDR_WIDTH  RAM read address
rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after rd_addr
tx_data  out  8  output byte
tx_valid  out  1  byte valid
tx_ready  in  1  downstream accept

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, rd_addr=0; internal counters cleared. Reset mid-job abandons the job; no further bytes are emitted.
- Handshake: a byte transfers on a clk edge with tx_valid&&tx_ready. Once tx_valid is raised, tx_data stays stable until the transfer. tx_valid may not drop without a transfer.
- start while busy is ignored. start in IDLE is accepted the same cycle; busy rises next cycle.
- FSM states:
  - IDLE: wait for start; load addr and remaining count. If count==0, go to EOL, else go to FETCH.
  - FETCH: drive rd_addr=addr; go to WAIT.
  - WAIT: capture rd_data; go to SIGN.
  - SIGN: if value is negative, emit '-' (8'h2D); magnitude = two's-complement negation held as unsigned 32 bits (so -2147483648 gives 2147483648). Then go to DIGIT with power index 9.
  - DIGIT: compare magnitude against pow10[idx].
    - If magnitude >= pow10[idx]: subtract and digit++ (one subtraction per cycle).
    - Else the digit is final: if digit!=0, or a nonzero digit was already emitted, or idx==0, emit 8'h30+digit and set started. Then idx--, digit=0. After idx 0, go to NEXT.
  - NEXT: addr++ (wraps mod 2^ADDR_WIDTH), remaining--. If remaining!=0, emit SEP_CHAR and go to FETCH; else go to EOL.
  - EOL: emit EOL_CHAR.
  - DONE: pulse done for 1 cycle with busy dropping the same cycle; return to IDLE.
- Emit means: present the byte with tx_valid=1 and stall the FSM until the transfer completes.
- Zero prints "0". No leading zeros. No '+'. No trailing SEP_CHAR.
- A digit never exceeds 9, because the magnitude is less than 10^10.

Optional Feature:
NUM_FMT_HEX_EN
- Defined: adds input hex_mode (1 bit, sampled on start). When hex_mode=1, each value prints as exactly 8 uppercase hex digits ('0'-'9', 'A'-'F'), unsigned, with leading zeros and no '-'. The SIGN/DIGIT states are bypassed by a nibble shifter. Separator and EOL rules are unchanged.
- Undefined: no hex_mode port; decimal only.

Decomposition:
- Package num_fmt_pkg holds:
  - fmt_state_t enum;
  - POW10 constant array [0:9] of 32-bit values;
  - ASCII_ZERO and ASCII_MINUS constants;
  - NUM_DIGITS=10.
- One sub-module, dec_digit_serializer: holds magnitude, idx, digit and started, plus the subtract loop. Interface: load, next_digit handshake, digit_out, emit flag and last flag.
- The top level owns the FSM, RAM addressing and the TX handshake.

Test Plan:
- RAM[5]=123, base_addr=5, num_count=1, tx_ready=1 -> bytes 31 32 33 0A; done pulses once; rd_addr=5.
- RAM[0..2]={0,-7,2147483647}, count=3 -> "0 -7 2147483647\n".
- RAM[0]=32'h80000000 -> "-2147483648\n"; RAM[0]=1000000000 -> "1000000000\n".
- base_addr=2047, count=2, RAM[2047]=4, RAM[0]=9 -> rd_addr wraps 2047 then 0; output "4 9\n". Separately, count=0 -> single 0A, then done.
- Random tx_ready backpressure (30% high) on the list {42,-1} -> tx_data is stable while stalled, each byte appears exactly once, and the stream is "42 -1\n". A start pulsed mid-job is ignored.
- Reset asserted mid-number -> tx_valid=0, busy=0 immediately; a new start afterwards prints correctly.
- With NUM_FMT_HEX_EN and hex_mode=1, RAM[0]=-1 -> "FFFFFFFF\n".

Source files
------------

// File: rtl/num_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : num_fmt_pkg
// Description : Shared types and constants for the number-to-ASCII formatter.
//               Holds the formatter state encoding, the decimal power table
//               used by the repeated-subtraction digit extractor, the ASCII
//               constants and a nibble-to-ASCII helper for the hex option.
// Revision    : 1.0 - initial release
// ============================================================================
package num_fmt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_WAIT  = 4'd2,
        ST_SIGN  = 4'd3,
        ST_DIGIT = 4'd4,
        ST_NEXT  = 4'd5,
        ST_EOL   = 4'd6,
        ST_DONE  = 4'd7,
        ST_HEX   = 4'd8
    } fmt_state_t;

    localparam int NUM_DIGITS = 10;

    localparam logic [31:0] POW10 [0:NUM_DIGITS-1] = '{
        32'd1,
        32'd10,
        32'd100,
        32'd1000,
        32'd10000,
        32'd100000,
        32'd1000000,
        32'd10000000,
        32'd100000000,
        32'd1000000000
    };

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // Uppercase hex digit: 'A' is 8'h41 = 8'h37 + 10.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dec_digit_serializer
// Description : Converts a 32-bit unsigned magnitude into decimal digits,
//               most significant first, by repeated subtraction of powers of
//               ten (one subtraction per cycle).
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_load, i_value   - start a new conversion of i_value
//               o_digit_valid     - current digit is final (held until consumed)
//               o_digit_out       - current digit value 0..9
//               o_emit            - digit must be printed (not a leading zero)
//               o_last            - current digit is the units digit
//               i_next_digit      - consumer has taken/skipped the digit
// Revision    : 1.0 - initial release
// ============================================================================
module dec_digit_serializer
    import num_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_value,
    input  logic        i_next_digit,
    output logic        o_digit_valid,
    output logic [3:0]  o_digit_out,
    output logic        o_emit,
    output logic        o_last
);

    logic [31:0] r_mag;
    logic [3:0]  r_idx;
    logic [3:0]  r_digit;
    logic        r_started;
    logic        r_active;

    logic [31:0] w_pow;
    logic        w_final;

    assign w_pow   = POW10[r_idx];
    // Digit is settled once the remainder drops below the current power.
    assign w_final = r_active && (r_mag < w_pow);

    assign o_digit_valid = w_final;
    assign o_digit_out   = r_digit;
    assign o_last        = (r_idx == 4'd0);
    // Units digit always prints so that zero renders as "0".
    assign o_emit        = (r_digit != 4'd0) || r_started || (r_idx == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag     <= '0;
            r_idx     <= '0;
            r_digit   <= '0;
            r_started <= 1'b0;
            r_active  <= 1'b0;
        end else if (i_load) begin
            r_mag     <= i_value;
            r_idx     <= 4'(NUM_DIGITS - 1);
            r_digit   <= '0;
            r_started <= 1'b0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (!w_final) begin
                r_mag   <= r_mag - w_pow;
                r_digit <= r_digit + 4'd1;
            end else if (i_next_digit) begin
                if (o_emit) begin
                    r_started <= 1'b1;
                end
                r_digit <= '0;
                if (r_idx == 4'd0) begin
                    r_active <= 1'b0;
                end else begin
                    r_idx <= r_idx - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/num_ascii_formatter.sv
`default_nettype none
// ============================================================================
// Module      : num_ascii_formatter
// Description : Reads signed integers from the number RAM (1-cycle registered
//               read) and streams them as decimal ASCII, separated by
//               SEP_CHAR and terminated by EOL_CHAR, over a valid/ready byte
//               interface.
// Ports       : clk, rst_n             - clock, async active-low reset
//               start                  - job request, accepted when idle
//               base_addr, num_count   - first address and number count
//               busy, done             - job status, done is a 1-cycle pulse
//               rd_addr, rd_data       - RAM read port
//               tx_data, tx_valid,
//               tx_ready               - output byte stream
//               hex_mode               - (NUM_FMT_HEX_EN only) print values as
//                                        8 uppercase hex digits
// Options     : NUM_FMT_HEX_EN - adds the hex_mode input and nibble shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module num_ascii_formatter
    import num_fmt_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 11,
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter logic [7:0] EOL_CHAR   = 8'h0A
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef NUM_FMT_HEX_EN
    input  logic                  hex_mode,
`endif
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("num_ascii_formatter supports DATA_WIDTH = 32 only");
        end
    endgenerate

    fmt_state_t            r_state;
    fmt_state_t            w_state_nx;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [31:0]           r_value;

    logic [31:0]           w_magnitude;
    logic                  w_ser_load;
    logic                  w_ser_next;
    logic                  w_dig_valid;
    logic [3:0]            w_dig;
    logic                  w_dig_emit;
    logic                  w_dig_last;
    logic                  w_hex_sel;

    // Two's-complement negation kept as unsigned, so 0x80000000 maps to 2^31.
    assign w_magnitude = r_value[31] ? (~r_value + 32'd1) : r_value;

    assign rd_addr = r_addr;
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);

    dec_digit_serializer u_dec (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_ser_load),
        .i_value      (w_magnitude),
        .i_next_digit (w_ser_next),
        .o_digit_valid(w_dig_valid),
        .o_digit_out  (w_dig),
        .o_emit       (w_dig_emit),
        .o_last       (w_dig_last)
    );

`ifdef NUM_FMT_HEX_EN
    logic        r_hex_mode;
    logic [31:0] r_hex_sh;
    logic [2:0]  r_hex_cnt;

    assign w_hex_sel = r_hex_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex_mode <= 1'b0;
            r_hex_sh   <= '0;
            r_hex_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_hex_mode <= hex_mode;
            end
            if ((r_state == ST_SIGN) && (w_state_nx == ST_HEX)) begin
                r_hex_sh  <= r_value;
                r_hex_cnt <= '0;
            end else if ((r_state == ST_HEX) && tx_ready) begin
                r_hex_sh  <= {r_hex_sh[27:0], 4'h0};
                r_hex_cnt <= r_hex_cnt + 3'd1;
            end
        end
    end
`else
    assign w_hex_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        done       = 1'b0;
        w_ser_load = 1'b0;
        w_ser_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = (num_count == '0) ? ST_EOL : ST_FETCH;
                end
            end
            ST_FETCH: w_state_nx = ST_WAIT;
            ST_WAIT:  w_state_nx = ST_SIGN;
            ST_SIGN: begin
                if (w_hex_sel) begin
                    w_state_nx = ST_HEX;
                end else if (r_value[31]) begin
                    tx_valid = 1'b1;
                    tx_data  = ASCII_MINUS;
                    if (tx_ready) begin
                        w_ser_load = 1'b1;
                        w_state_nx = ST_DIGIT;
                    end
                end else begin
                    w_ser_load = 1'b1;
                    w_state_nx = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (w_dig_valid) begin
                    if (w_dig_emit) begin
                        tx_valid   = 1'b1;
                        tx_data    = ASCII_ZERO + {4'h0, w_dig};
                        w_ser_next = tx_ready;
                    end else begin
                        // Leading zero: drop it without touching the stream.
                        w_ser_next = 1'b1;
                    end
                    if (w_ser_next && w_dig_last) begin
                        w_state_nx = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (r_remaining != (ADDR_WIDTH+1)'(1)) begin
                    tx_valid = 1'b1;
                    tx_data  = SEP_CHAR;
                    if (tx_ready) begin
                        w_state_nx = ST_FETCH;
                    end
                end else begin
                    w_state_nx = ST_EOL;
                end
            end
            ST_EOL: begin
                tx_valid = 1'b1;
                tx_data  = EOL_CHAR;
                if (tx_ready) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                w_state_nx = ST_IDLE;
            end
`ifdef NUM_FMT_HEX_EN
            ST_HEX: begin
                tx_valid = 1'b1;
                tx_data  = hex_ascii(r_hex_sh[31:28]);
                if (tx_ready && (r_hex_cnt == 3'd7)) begin
                    w_state_nx = ST_NEXT;
                end
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_value     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= num_count;
                    end
                end
                ST_WAIT: r_value <= rd_data;
                ST_NEXT: begin
                    // Address wraps naturally modulo 2^ADDR_WIDTH.
                    if (w_state_nx != ST_NEXT) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
